mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: signal bundle around mem_port_arbiter (I-fetch port, load/store port, RAM port, error report).
// Latency: none, wires only.
// Backpressure: i_stall/d_stall back to the requesters; mem_ack from the RAM ends each access.
// Modports: slave = arbiter view (requests and RAM results in, stalls/RAM strobes out);
//           master = pipeline/RAM/bench view (the mirror image).
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_stall;
  // load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  // shared RAM port
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;
  // timeout reporting
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ack, err_clr,
    output i_rdata, i_stall, d_rdata, d_stall, mem_cs, mem_we, mem_addr, mem_din, err, err_addr
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ack, err_clr,
    input  i_rdata, i_stall, d_rdata, d_stall, mem_cs, mem_we, mem_addr, mem_din, err, err_addr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one multi-cycle RAM port between I-fetch and load/store, aborting hung accesses.
// Latency: request seen in IDLE -> >=1 SERVE cycle -> RESP (done); min 3 cycles until the requester advances.
// Backpressure: each stall stays high while its req is pending and drops only in its one RESP cycle.
// Ports: clk, rst (synchronous, active-high); bus (mem_port_arbiter_if.slave) carries
//        i_* / d_* requester handshakes, mem_* RAM strobes, and err/err_addr/err_clr.
// Params: PRIORITY (0 round-robin, 1 D always wins), TIMEOUT (1..255 SERVE cycles),
//         RESET_DMASK (initial last_owner; 1 lets I win the first tie).
module mem_port_arbiter #(
  parameter int          PRIORITY    = 0,
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          RESET_DMASK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam bit         D_ALWAYS_WINS = (PRIORITY != 0);
  // Counter value in the last SERVE cycle allowed before the access is abandoned.
  localparam logic [7:0] CNT_LAST      = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;           // 0 = I, 1 = D
  logic        last_owner_q, last_owner_d; // owner of the last completed access
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        grant_to_d;
  logic        i_done;
  logic        d_done;

  // D wins when I is absent, when D has fixed priority, or when I was served last.
  assign grant_to_d = bus.d_req & (~bus.i_req | D_ALWAYS_WINS | ~last_owner_q);

  // Done is simply "RESP for this owner", so it lasts exactly one cycle.
  assign i_done = (state_q == RESP) && !owner_q;
  assign d_done = (state_q == RESP) &&  owner_q;

  assign bus.i_stall  = bus.i_req & ~i_done;
  assign bus.d_stall  = bus.d_req & ~d_done;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_cs   = (state_q == SERVE);
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. A reset mid-SERVE simply drops the access: no RESP, so no done.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_owner_q <= RESET_DMASK;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_we_q     <= mem_we_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_we_d     = mem_we_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // Latch the winner's request so the RAM sees stable inputs for the whole access,
          // even if the requester misbehaves and changes its inputs meanwhile.
          owner_d = grant_to_d;
          cnt_d   = '0;
          state_d = SERVE;
          if (grant_to_d) begin
            mem_addr_d = bus.d_addr;
            mem_we_d   = bus.d_we;
            mem_din_d  = bus.d_wdata;
          end else begin
            mem_addr_d = bus.i_addr;
            mem_we_d   = 1'b0;
            mem_din_d  = '0;
          end
        end
      end

      SERVE: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mem_ack) begin
          // An ack in the final allowed cycle still counts as a normal completion.
          state_d  = RESP;
          mem_we_d = 1'b0;
          if (owner_q) begin
            d_rdata_d = bus.mem_dout;
          end else begin
            i_rdata_d = bus.mem_dout;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          mem_we_d = 1'b0;
          if (owner_q) begin
            d_rdata_d = '0;
          end else begin
            i_rdata_d = '0;
          end
          // Only the first hung address is kept until software clears it.
          if (!err_q) begin
            err_d      = 1'b1;
            err_addr_d = mem_addr_q;
          end
        end
      end

      RESP: begin
        // Passing through IDLE afterwards leaves a cs-low cycle between accesses.
        last_owner_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clearing beats a simultaneous new timeout.
    if (bus.err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (round-robin and D-priority instances).
// Latency: n/a (testbench).
// Backpressure: a small RAM responder acks after a programmable number of SERVE cycles (0 = never).
module tb_mem_port_arbiter;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if b0();
  mem_port_arbiter_if b1();

  mem_port_arbiter #(.PRIORITY(0), .TIMEOUT(TO), .RESET_DMASK(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  mem_port_arbiter #(.PRIORITY(1), .TIMEOUT(TO), .RESET_DMASK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // RAM responder for dut0: ack in SERVE cycle number ack_lat0; garbage on mem_dout otherwise.
  int          ack_lat0;
  logic [31:0] rd_val0;
  int          serve_n0 = 0;
  always @(negedge clk) begin
    if (b0.mem_cs === 1'b1) begin
      serve_n0 = serve_n0 + 1;
      if (ack_lat0 != 0 && serve_n0 == ack_lat0) begin
        b0.mem_ack  = 1'b1;
        b0.mem_dout = rd_val0;
      end else begin
        b0.mem_ack  = 1'b0;
        b0.mem_dout = $urandom;
      end
    end else begin
      serve_n0    = 0;
      b0.mem_ack  = 1'b0;
      b0.mem_dout = $urandom;
    end
  end

  // RAM responder for dut1: ack in the 2nd SERVE cycle, data = ~address.
  int serve_n1 = 0;
  always @(negedge clk) begin
    if (b1.mem_cs === 1'b1) begin
      serve_n1    = serve_n1 + 1;
      b1.mem_ack  = (serve_n1 == 2) ? 1'b1 : 1'b0;
      b1.mem_dout = ~b1.mem_addr;
    end else begin
      serve_n1    = 0;
      b1.mem_ack  = 1'b0;
      b1.mem_dout = 32'h0;
    end
  end

  // Reference model: an access with ack latency lat occupies min(lat, TO) SERVE cycles,
  // completes normally only if 1 <= lat <= TO, and the requester sees done one cycle later.
  function automatic int exp_serve(input int lat);
    return (lat >= 1 && lat <= TO) ? lat : TO;
  endfunction
  function automatic bit exp_acked(input int lat);
    return (lat >= 1 && lat <= TO);
  endfunction

  logic [31:0] m_i_rdata, m_d_rdata, m_err_addr;
  bit          m_err, m_last_d;

  // Runs one single-requester access on dut0 and reports what was observed.
  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rv,
                        output int n_serve, output int n_wait, output logic [31:0] rdata,
                        output logic [31:0] seen_addr, output logic seen_we, output logic [31:0] seen_din,
                        output bit stable, output bit other_stall);
    @(negedge clk);
    ack_lat0 = lat;
    rd_val0  = rv;
    if (is_d) begin
      b0.d_req = 1'b1; b0.d_we = we; b0.d_addr = addr; b0.d_wdata = wdata;
    end else begin
      b0.i_req = 1'b1; b0.i_addr = addr;
    end
    n_serve = 0; n_wait = 0; rdata = '0; seen_addr = '0; seen_we = 1'b0; seen_din = '0;
    stable = 1'b1; other_stall = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_wait++;
      if (b0.mem_cs === 1'b1) begin
        if (n_serve == 0) begin
          seen_addr = b0.mem_addr; seen_we = b0.mem_we; seen_din = b0.mem_din;
        end else if (b0.mem_addr !== seen_addr || b0.mem_we !== seen_we || b0.mem_din !== seen_din) begin
          stable = 1'b0;
        end
        n_serve++;
      end
      if ((is_d ? b0.i_stall : b0.d_stall) !== 1'b0) other_stall = 1'b1;
      if ((is_d ? b0.d_stall : b0.i_stall) === 1'b0) begin
        rdata = is_d ? b0.d_rdata : b0.i_rdata;
        break;
      end
    end
    b0.i_req = 1'b0;
    b0.d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (b0.mem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_mem_cs got=%h exp=0", b0.mem_cs); end
    n_checks++; if (b0.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%h exp=0", b0.mem_we); end
    n_checks++; if (b0.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", b0.mem_addr); end
    n_checks++; if (b0.mem_din !== 32'h0) begin n_fail++; $display("FAIL rst_mem_din got=%h exp=0", b0.mem_din); end
    n_checks++; if (b0.i_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_i_rdata got=%h exp=0", b0.i_rdata); end
    n_checks++; if (b0.d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got=%h exp=0", b0.d_rdata); end
    n_checks++; if (b0.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%h exp=0", b0.err); end
    n_checks++; if (b0.err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_err_addr got=%h exp=0", b0.err_addr); end
    n_checks++; if ({b0.i_stall, b0.d_stall} !== 2'b00) begin n_fail++; $display("FAIL rst_stalls got=%b exp=00", {b0.i_stall, b0.d_stall}); end
    rst = 1'b0;
  endtask

  task automatic test_i_read();
    int ns, nw; logic [31:0] rd, sa, sd; logic sw; bit st, os;
    do_txn(1'b0, 1'b0, 32'h4, 32'h0, 3, 32'hDEADBEEF, ns, nw, rd, sa, sw, sd, st, os);
    n_checks++; if (ns != 3) begin n_fail++; $display("FAIL iread_cs_cycles got=%0d exp=3", ns); end
    n_checks++; if (nw != 4) begin n_fail++; $display("FAIL iread_stall_cycles got=%0d exp=4", nw); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iread_rdata got=%h exp=deadbeef", rd); end
    n_checks++; if (sa !== 32'h4 || sw !== 1'b0 || sd !== 32'h0) begin n_fail++; $display("FAIL iread_bus got=%h/%h/%h exp=4/0/0", sa, sw, sd); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL iread_stable got=%0d exp=1", st); end
    n_checks++; if (os) begin n_fail++; $display("FAIL iread_d_stall got=%0d exp=0", os); end
    n_checks++; if (b0.d_rdata !== 32'h0) begin n_fail++; $display("FAIL iread_d_rdata_hold got=%h exp=0", b0.d_rdata); end
  endtask

  task automatic test_d_write();
    int ns, nw; logic [31:0] rd, sa, sd; logic sw; bit st, os;
    do_txn(1'b1, 1'b1, 32'h10, 32'h12345678, 2, $urandom, ns, nw, rd, sa, sw, sd, st, os);
    n_checks++; if (ns != 2 || nw != 3) begin n_fail++; $display("FAIL dwr_cycles got=%0d/%0d exp=2/3", ns, nw); end
    n_checks++; if (sa !== 32'h10 || sw !== 1'b1 || sd !== 32'h12345678) begin n_fail++; $display("FAIL dwr_bus got=%h/%h/%h exp=10/1/12345678", sa, sw, sd); end
    n_checks++; if (!st || os) begin n_fail++; $display("FAIL dwr_stable_other got=%0d/%0d exp=1/0", st, os); end
    n_checks++; if (b0.i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dwr_i_rdata_hold got=%h exp=deadbeef", b0.i_rdata); end
    n_checks++; if (b0.mem_we !== 1'b0) begin n_fail++; $display("FAIL dwr_we_after got=%h exp=0", b0.mem_we); end
  endtask

  task automatic test_timeout();
    int ns, nw; logic [31:0] rd, sa, sd, rv; logic sw; bit st, os;
    @(negedge clk); b0.err_clr = 1'b1; @(negedge clk); b0.err_clr = 1'b0;
    do_txn(1'b1, 1'b0, 32'h14, 32'h0, 0, $urandom, ns, nw, rd, sa, sw, sd, st, os);
    n_checks++; if (ns != TO || nw != TO + 1) begin n_fail++; $display("FAIL to_cycles got=%0d/%0d exp=%0d/%0d", ns, nw, TO, TO + 1); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", rd); end
    n_checks++; if (b0.err !== 1'b1 || b0.err_addr !== 32'h14) begin n_fail++; $display("FAIL to_err got=%h/%h exp=1/14", b0.err, b0.err_addr); end
    do_txn(1'b1, 1'b0, 32'h18, 32'h0, 0, $urandom, ns, nw, rd, sa, sw, sd, st, os);
    n_checks++; if (b0.err !== 1'b1 || b0.err_addr !== 32'h14) begin n_fail++; $display("FAIL to_sticky got=%h/%h exp=1/14", b0.err, b0.err_addr); end
    @(negedge clk); b0.err_clr = 1'b1; @(negedge clk); b0.err_clr = 1'b0;
    n_checks++; if (b0.err !== 1'b0 || b0.err_addr !== 32'h0) begin n_fail++; $display("FAIL to_clear got=%h/%h exp=0/0", b0.err, b0.err_addr); end
    // Ack in the last allowed SERVE cycle completes normally.
    rv = $urandom;
    do_txn(1'b0, 1'b0, 32'h1C, 32'h0, TO, rv, ns, nw, rd, sa, sw, sd, st, os);
    n_checks++; if (ns != TO || rd !== rv || b0.err !== 1'b0) begin n_fail++; $display("FAIL to_ack_edge got=%0d/%h/%h exp=%0d/%h/0", ns, rd, b0.err, TO, rv); end
    // Clear held across a timeout keeps err low.
    b0.err_clr = 1'b1;
    do_txn(1'b1, 1'b0, 32'h24, 32'h0, 0, $urandom, ns, nw, rd, sa, sw, sd, st, os);
    b0.err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (b0.err !== 1'b0 || b0.err_addr !== 32'h0) begin n_fail++; $display("FAIL to_clr_priority got=%h/%h exp=0/0", b0.err, b0.err_addr); end
  endtask

  task automatic test_random();
    int ns, nw, lat; logic [31:0] rd, sa, sd, addr, wdata, rv; logic sw; bit st, os, is_d, we, acked;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0; m_err = 1'b0; m_err_addr = '0;
    for (int n = 0; n < 40; n++) begin
      is_d  = 1'($urandom_range(0, 1));
      we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      lat   = int'($urandom_range(0, 18));
      rv    = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); b0.err_clr = 1'b1; @(negedge clk); b0.err_clr = 1'b0;
        m_err = 1'b0; m_err_addr = '0;
      end
      do_txn(is_d, we, addr, wdata, lat, rv, ns, nw, rd, sa, sw, sd, st, os);
      acked = exp_acked(lat);
      if (is_d) m_d_rdata = acked ? rv : 32'h0;
      else      m_i_rdata = acked ? rv : 32'h0;
      if (!acked && !m_err) begin m_err = 1'b1; m_err_addr = addr; end
      n_checks++; if (ns != exp_serve(lat) || nw != exp_serve(lat) + 1) begin n_fail++; $display("FAIL rnd%0d_cycles got=%0d/%0d exp=%0d/%0d", n, ns, nw, exp_serve(lat), exp_serve(lat) + 1); end
      n_checks++; if (sa !== addr || sw !== (is_d & we) || sd !== (is_d ? wdata : 32'h0)) begin n_fail++; $display("FAIL rnd%0d_bus got=%h/%h/%h exp=%h/%h/%h", n, sa, sw, sd, addr, is_d & we, is_d ? wdata : 32'h0); end
      n_checks++; if (!st || os) begin n_fail++; $display("FAIL rnd%0d_stable_other got=%0d/%0d exp=1/0", n, st, os); end
      n_checks++; if (b0.i_rdata !== m_i_rdata || b0.d_rdata !== m_d_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got=%h/%h exp=%h/%h", n, b0.i_rdata, b0.d_rdata, m_i_rdata, m_d_rdata); end
      n_checks++; if (b0.err !== m_err || b0.err_addr !== m_err_addr) begin n_fail++; $display("FAIL rnd%0d_err got=%h/%h exp=%h/%h", n, b0.err, b0.err_addr, m_err, m_err_addr); end
    end
  endtask

  task automatic test_round_robin();
    int grants, i_dn, d_dn; bit prev_cs, exp_d;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_last_d = 1'b1;
    ack_lat0 = int'($urandom_range(1, 4)); rd_val0 = $urandom;
    b0.i_addr = 32'h8; b0.d_addr = 32'hC; b0.d_we = 1'b0; b0.i_req = 1'b1; b0.d_req = 1'b1;
    grants = 0; i_dn = 0; d_dn = 0; prev_cs = 1'b0; exp_d = 1'b0;
    for (int c = 0; c < 200 && (i_dn + d_dn) < 8; c++) begin
      @(negedge clk);
      if (b0.mem_cs === 1'b1 && !prev_cs) begin
        grants++;
        exp_d = !m_last_d;
        n_checks++; if (b0.mem_addr !== (exp_d ? 32'hC : 32'h8)) begin n_fail++; $display("FAIL rr_grant%0d_addr got=%h exp=%h", grants, b0.mem_addr, exp_d ? 32'hC : 32'h8); end
      end
      prev_cs = (b0.mem_cs === 1'b1);
      if (b0.i_stall === 1'b0) begin
        i_dn++;
        n_checks++; if (exp_d || b0.i_rdata !== rd_val0) begin n_fail++; $display("FAIL rr_i_done got=owner_d%0d/%h exp=owner_d0/%h", exp_d, b0.i_rdata, rd_val0); end
        m_last_d = 1'b0;
      end
      if (b0.d_stall === 1'b0) begin
        d_dn++;
        n_checks++; if (!exp_d || b0.d_rdata !== rd_val0) begin n_fail++; $display("FAIL rr_d_done got=owner_d%0d/%h exp=owner_d1/%h", exp_d, b0.d_rdata, rd_val0); end
        m_last_d = 1'b1;
      end
    end
    b0.i_req = 1'b0; b0.d_req = 1'b0;
    n_checks++; if (grants != 8 || i_dn != 4 || d_dn != 4) begin n_fail++; $display("FAIL rr_counts got=%0d/%0d/%0d exp=8/4/4", grants, i_dn, d_dn); end
  endtask

  task automatic test_priority();
    int grants, d_dn, i_low, bad_addr; bit prev_cs;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    b1.i_addr = 32'h8; b1.d_addr = 32'hC; b1.d_we = 1'b0; b1.d_wdata = 32'h0;
    b1.i_req = 1'b1; b1.d_req = 1'b1;
    grants = 0; d_dn = 0; i_low = 0; bad_addr = 0; prev_cs = 1'b0;
    for (int c = 0; c < 200 && d_dn < 5; c++) begin
      @(negedge clk);
      if (b1.mem_cs === 1'b1 && !prev_cs) begin
        grants++;
        if (b1.mem_addr !== 32'hC) bad_addr++;
      end
      prev_cs = (b1.mem_cs === 1'b1);
      if (b1.i_stall !== 1'b1) i_low++;
      if (b1.d_stall === 1'b0) d_dn++;
    end
    n_checks++; if (grants != 5 || d_dn != 5 || bad_addr != 0) begin n_fail++; $display("FAIL prio_grants got=%0d/%0d/%0d exp=5/5/0", grants, d_dn, bad_addr); end
    n_checks++; if (i_low != 0) begin n_fail++; $display("FAIL prio_i_stall_low got=%0d exp=0", i_low); end
    n_checks++; if (b1.d_rdata !== ~32'hC) begin n_fail++; $display("FAIL prio_d_rdata got=%h exp=%h", b1.d_rdata, ~32'hC); end
    b1.i_req = 1'b0; b1.d_req = 1'b0;
  endtask

  task automatic test_reset_mid_serve();
    int serve, i_low, waited; bit got;
    ack_lat0 = 0; rd_val0 = $urandom;
    @(negedge clk);
    b0.i_addr = 32'h20; b0.i_req = 1'b1;
    serve = 0; i_low = 0;
    for (int c = 0; c < 10 && serve < 2; c++) begin
      @(negedge clk);
      if (b0.mem_cs === 1'b1) serve++;
      if (b0.i_stall !== 1'b1) i_low++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (serve != 2 || i_low != 0) begin n_fail++; $display("FAIL rstmid_pre got=%0d/%0d exp=2/0", serve, i_low); end
    n_checks++; if (b0.mem_cs !== 1'b0) begin n_fail++; $display("FAIL rstmid_cs got=%h exp=0", b0.mem_cs); end
    n_checks++; if (b0.i_stall !== 1'b1 || b0.i_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_done got=%h/%h exp=1/0", b0.i_stall, b0.i_rdata); end
    rst = 1'b0; ack_lat0 = 2;
    @(negedge clk);
    n_checks++; if (b0.mem_cs !== 1'b1 || b0.mem_addr !== 32'h20) begin n_fail++; $display("FAIL rstmid_regrant got=%h/%h exp=1/20", b0.mem_cs, b0.mem_addr); end
    got = 1'b0; waited = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      waited++;
      if (b0.i_stall === 1'b0) got = 1'b1;
    end
    n_checks++; if (!got || waited != 2 || b0.i_rdata !== rd_val0) begin n_fail++; $display("FAIL rstmid_complete got=%0d/%0d/%h exp=1/2/%h", got, waited, b0.i_rdata, rd_val0); end
    b0.i_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ack_lat0 = 0; rd_val0 = '0;
    b0.i_req = 1'b0; b0.i_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0; b0.err_clr = 1'b0;
    b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0; b1.err_clr = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_timeout();
    test_random();
    test_round_robin();
    test_priority();
    test_reset_mid_serve();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
